// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store memory access stage with bus handshake, alignment check and timeout
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Done,
   output logic        MisalignErr,
   output logic        TimeoutErr,
   output logic        Stall,
   output logic        BusReq,
   output logic        BusWe,
   output logic [31:0] BusAddr,
   output logic [31:0] BusWData,
   output logic [3:0]  BusBe,
   input  logic [31:0] BusRData,
   input  logic        BusAck
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;

   // Operation attributes captured at acceptance, needed to format the load result
   logic [1:0]    op_size;
   logic          op_uns;
   logic          op_read;
   logic [1:0]    op_lane;

   logic          accept, misalign, go, ack_hit, tmo_hit;
   logic [3:0]    be_nxt;
   logic [31:0]   wd_nxt;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   rd_fmt;

   assign Stall  = (state == ACCESS);
   assign BusReq = (state == ACCESS);

   // Request qualification, alignment check and FSM next-state
   always_comb begin
      accept   = 1'b0;
      misalign = 1'b0;
      go       = 1'b0;
      ack_hit  = 1'b0;
      tmo_hit  = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            accept   = Start && (MemRead ^ MemWrite) && (Size != 2'b11);
            misalign = ((Size == 2'b01) && Addr[0]) ||
                       ((Size == 2'b10) && (Addr[1:0] != 2'b00));
            go       = accept && !misalign;
            if (go) state_nxt = ACCESS;
         end
         ACCESS: begin
            // An ack on the last allowed cycle completes normally rather than timing out
            ack_hit = BusAck;
            tmo_hit = !BusAck && (cnt == CNT_LAST);
            if (ack_hit || tmo_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Byte enables and lane-replicated write data for the incoming request
   always_comb begin
      be_nxt = 4'b1111;
      wd_nxt = WriteData;
      case (Size)
         2'b00: begin
            be_nxt = 4'b0001 << Addr[1:0];
            wd_nxt = {4{WriteData[7:0]}};
         end
         2'b01: begin
            be_nxt = Addr[1] ? 4'b1100 : 4'b0011;
            wd_nxt = {2{WriteData[15:0]}};
         end
         default: begin
            be_nxt = 4'b1111;
            wd_nxt = WriteData;
         end
      endcase
   end

   // Lane select and sign/zero extension of the returned bus word
   always_comb begin
      rd_byte = BusRData[7:0];
      case (op_lane)
         2'd1:    rd_byte = BusRData[15:8];
         2'd2:    rd_byte = BusRData[23:16];
         2'd3:    rd_byte = BusRData[31:24];
         default: rd_byte = BusRData[7:0];
      endcase
      rd_half = op_lane[1] ? BusRData[31:16] : BusRData[15:0];
      rd_fmt  = BusRData;
      if (op_size == 2'b00)
         rd_fmt = {{24{~op_uns & rd_byte[7]}}, rd_byte};
      else if (op_size == 2'b01)
         rd_fmt = {{16{~op_uns & rd_half[15]}}, rd_half};
   end

   // State register and wait-cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (go)
            cnt <= '0;
         else if (state == ACCESS && !BusAck)
            cnt <= cnt + 1'b1;
      end
   end

   // One-cycle status pulses, raised the cycle after the deciding edge
   always_ff @(posedge clk) begin
      if (reset) begin
         Done        <= 1'b0;
         MisalignErr <= 1'b0;
         TimeoutErr  <= 1'b0;
      end else begin
         Done        <= ack_hit;
         MisalignErr <= accept && misalign;
         TimeoutErr  <= tmo_hit;
      end
   end

   // Bus request fields, captured on acceptance and held until the next access
   always_ff @(posedge clk) begin
      if (reset) begin
         BusWe    <= 1'b0;
         BusAddr  <= '0;
         BusWData <= '0;
         BusBe    <= '0;
         op_size  <= '0;
         op_uns   <= 1'b0;
         op_read  <= 1'b0;
         op_lane  <= '0;
      end else if (go) begin
         BusWe    <= MemWrite;
         BusAddr  <= {Addr[31:2], 2'b00};
         BusWData <= wd_nxt;
         BusBe    <= be_nxt;
         op_size  <= Size;
         op_uns   <= Unsigned;
         op_read  <= MemRead;
         op_lane  <= Addr[1:0];
      end
   end

   // Load result register, updated only when a read is acknowledged
   always_ff @(posedge clk) begin
      if (reset)
         ReadData <= '0;
      else if (ack_hit && op_read)
         ReadData <= rd_fmt;
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

   logic        clk, reset, Start, MemRead, MemWrite, Unsigned, BusAck;
   logic [1:0]  Size;
   logic [31:0] Addr, WriteData, BusRData;
   logic [31:0] ReadData, BusAddr, BusWData;
   logic        Done, MisalignErr, TimeoutErr, Stall, BusReq, BusWe;
   logic [3:0]  BusBe;

   int errors = 0;
   int checks = 0;

   mem_access_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
      .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WriteData(WriteData),
      .ReadData(ReadData), .Done(Done), .MisalignErr(MisalignErr), .TimeoutErr(TimeoutErr),
      .Stall(Stall), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
      .BusWData(BusWData), .BusBe(BusBe), .BusRData(BusRData), .BusAck(BusAck)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle_inputs();
      Start = 0; MemRead = 0; MemWrite = 0; Size = 2'b00; Unsigned = 0;
      Addr = 0; WriteData = 0; BusAck = 0; BusRData = 0;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
      Start = 1; MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Addr = a; WriteData = wd;
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      repeat (2) @(negedge clk);
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
      checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL reset_busreq: got %b want 0", BusReq); end
      checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 0", ReadData); end
      checks++; if ({Done, MisalignErr, TimeoutErr, BusWe} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {Done, MisalignErr, TimeoutErr, BusWe}); end
      checks++; if ({BusAddr, BusWData, BusBe} !== 68'h0) begin errors++; $display("FAIL reset_busfields: got %h %h %b want zeros", BusAddr, BusWData, BusBe); end
      reset = 0;
   endtask

   task automatic test_load_byte();
      @(negedge clk); idle_inputs(); issue(1, 0, 2'b00, 0, 32'h103, 0);
      @(negedge clk); Start = 0;
      checks++; if (BusReq !== 1'b1 || Stall !== 1'b1) begin errors++; $display("FAIL lb_req: got req=%b stall=%b want 1 1", BusReq, Stall); end
      checks++; if (BusAddr !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h want 00000100", BusAddr); end
      checks++; if (BusBe !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b want 1000", BusBe); end
      checks++; if (BusWe !== 1'b0) begin errors++; $display("FAIL lb_we: got %b want 0", BusWe); end
      @(negedge clk);
      checks++; if (BusReq !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL lb_wait: got req=%b done=%b want 1 0", BusReq, Done); end
      BusAck = 1; BusRData = 32'h80FFFFFF;
      @(negedge clk); BusAck = 0;
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL lb_done: got %b want 1", Done); end
      checks++; if (ReadData !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", ReadData); end
      checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL lb_reqdrop: got %b want 0", BusReq); end
      @(negedge clk);
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL lb_done_once: got %b want 0", Done); end
   endtask

   task automatic test_store_half();
      @(negedge clk); idle_inputs(); issue(0, 1, 2'b01, 0, 32'h42, 32'h1234ABCD);
      @(negedge clk); Start = 0;
      checks++; if (BusWe !== 1'b1 || BusReq !== 1'b1) begin errors++; $display("FAIL sh_we: got we=%b req=%b want 1 1", BusWe, BusReq); end
      checks++; if (BusBe !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", BusBe); end
      checks++; if (BusWData !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", BusWData); end
      checks++; if (BusAddr !== 32'h40) begin errors++; $display("FAIL sh_addr: got %h want 00000040", BusAddr); end
      BusAck = 1; BusRData = 32'h55555555;
      @(negedge clk); BusAck = 0;
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL sh_done: got %b want 1", Done); end
      checks++; if (ReadData !== 32'hFFFFFF80) begin errors++; $display("FAIL sh_rdhold: got %h want ffffff80", ReadData); end
   endtask

   task automatic test_load_half();
      @(negedge clk); idle_inputs(); issue(1, 0, 2'b01, 1, 32'h202, 0);
      @(negedge clk); Start = 0;
      checks++; if (BusBe !== 4'b1100 || BusAddr !== 32'h200) begin errors++; $display("FAIL lhu_bus: got be=%b addr=%h want 1100 00000200", BusBe, BusAddr); end
      BusAck = 1; BusRData = 32'h87654321;
      @(negedge clk); BusAck = 0;
      checks++; if (ReadData !== 32'h00008765 || Done !== 1'b1) begin errors++; $display("FAIL lhu_data: got %h done=%b want 00008765 1", ReadData, Done); end
      issue(1, 0, 2'b01, 0, 32'h200, 0);
      @(negedge clk); Start = 0;
      checks++; if (BusBe !== 4'b0011) begin errors++; $display("FAIL lh_be: got %b want 0011", BusBe); end
      BusAck = 1; BusRData = 32'h12349ABC;
      @(negedge clk); BusAck = 0;
      checks++; if (ReadData !== 32'hFFFF9ABC) begin errors++; $display("FAIL lh_data: got %h want ffff9abc", ReadData); end
   endtask

   task automatic test_misalign();
      @(negedge clk); idle_inputs(); issue(1, 0, 2'b10, 0, 32'h6, 0);
      @(negedge clk); Start = 0;
      checks++; if (MisalignErr !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", MisalignErr); end
      checks++; if (BusReq !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL mis_noreq: got req=%b stall=%b want 0 0", BusReq, Stall); end
      @(negedge clk);
      checks++; if (MisalignErr !== 1'b0 || BusReq !== 1'b0) begin errors++; $display("FAIL mis_once: got err=%b req=%b want 0 0", MisalignErr, BusReq); end
      checks++; if (ReadData !== 32'hFFFF9ABC) begin errors++; $display("FAIL mis_rdhold: got %h want ffff9abc", ReadData); end
   endtask

   task automatic test_timeout();
      int req_cycles = 0, terr_cnt = 0, terr_at = 0, done_cnt = 0;
      @(negedge clk); idle_inputs(); issue(1, 0, 2'b10, 0, 32'h10, 0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk); Start = 0;
         if (BusReq) req_cycles++;
         if (TimeoutErr) begin terr_cnt++; terr_at = k; end
         if (Done) done_cnt++;
      end
      checks++; if (req_cycles !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
      checks++; if (terr_cnt !== 1 || terr_at !== 5) begin errors++; $display("FAIL to_pulse: got count=%0d at=%0d want 1 at 5", terr_cnt, terr_at); end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL to_nodone: got %0d want 0", done_cnt); end
      checks++; if (ReadData !== 32'hFFFF9ABC) begin errors++; $display("FAIL to_rdhold: got %h want ffff9abc", ReadData); end
   endtask

   task automatic test_ack_on_timeout_cycle();
      @(negedge clk); idle_inputs(); issue(1, 0, 2'b10, 0, 32'h20, 0);
      repeat (3) begin @(negedge clk); Start = 0; end
      @(negedge clk);
      checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL tb_lastcycle: got req=%b want 1", BusReq); end
      BusAck = 1; BusRData = 32'hDEADBEEF;
      @(negedge clk); BusAck = 0;
      checks++; if (Done !== 1'b1 || TimeoutErr !== 1'b0) begin errors++; $display("FAIL tb_ackwins: got done=%b terr=%b want 1 0", Done, TimeoutErr); end
      checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL tb_data: got %h want deadbeef", ReadData); end
      @(negedge clk);
      checks++; if (Done !== 1'b0 || TimeoutErr !== 1'b0) begin errors++; $display("FAIL tb_after: got done=%b terr=%b want 0 0", Done, TimeoutErr); end
   endtask

   task automatic test_ignored();
      @(negedge clk); idle_inputs(); issue(1, 1, 2'b10, 0, 32'h8, 0);
      @(negedge clk);
      checks++; if ({Stall, BusReq, MisalignErr, Done, TimeoutErr} !== 5'b0) begin errors++; $display("FAIL ign_both: got %b want 00000", {Stall, BusReq, MisalignErr, Done, TimeoutErr}); end
      issue(1, 0, 2'b11, 0, 32'h1, 0);
      @(negedge clk); Start = 0;
      checks++; if ({Stall, BusReq, MisalignErr, Done, TimeoutErr} !== 5'b0) begin errors++; $display("FAIL ign_size11: got %b want 00000", {Stall, BusReq, MisalignErr, Done, TimeoutErr}); end
      BusAck = 1; BusRData = 32'h11111111;
      @(negedge clk); BusAck = 0;
      checks++; if (Done !== 1'b0 || ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL ign_idleack: got done=%b rd=%h want 0 deadbeef", Done, ReadData); end
      issue(1, 0, 2'b10, 0, 32'h30, 0);
      @(negedge clk);
      issue(0, 1, 2'b10, 0, 32'h5, 32'hCAFE);
      @(negedge clk); Start = 0;
      checks++; if (BusAddr !== 32'h30 || BusWe !== 1'b0 || Stall !== 1'b1) begin errors++; $display("FAIL ign_busy: got addr=%h we=%b stall=%b want 00000030 0 1", BusAddr, BusWe, Stall); end
      checks++; if (MisalignErr !== 1'b0) begin errors++; $display("FAIL ign_busy_mis: got %b want 0", MisalignErr); end
      BusAck = 1; BusRData = 32'h11111111;
      @(negedge clk); BusAck = 0;
      checks++; if (Done !== 1'b1 || ReadData !== 32'h11111111) begin errors++; $display("FAIL ign_busy_done: got done=%b rd=%h want 1 11111111", Done, ReadData); end
      @(negedge clk);
      checks++; if (Stall !== 1'b0 || MisalignErr !== 1'b0) begin errors++; $display("FAIL ign_noqueue: got stall=%b mis=%b want 0 0", Stall, MisalignErr); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); idle_inputs(); issue(1, 0, 2'b00, 1, 32'h1, 0);
      @(negedge clk); Start = 0;
      checks++; if (BusBe !== 4'b0010 || BusAddr !== 32'h0) begin errors++; $display("FAIL b2b_first: got be=%b addr=%h want 0010 00000000", BusBe, BusAddr); end
      BusAck = 1; BusRData = 32'h0000AA00;
      @(negedge clk); BusAck = 0;
      checks++; if (Done !== 1'b1 || BusReq !== 1'b0 || ReadData !== 32'hAA) begin errors++; $display("FAIL b2b_gap: got done=%b req=%b rd=%h want 1 0 000000aa", Done, BusReq, ReadData); end
      issue(0, 1, 2'b00, 0, 32'h3, 32'h5A);
      @(negedge clk); Start = 0;
      checks++; if (BusReq !== 1'b1 || BusWe !== 1'b1) begin errors++; $display("FAIL b2b_second: got req=%b we=%b want 1 1", BusReq, BusWe); end
      checks++; if (BusBe !== 4'b1000 || BusWData !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_fields: got be=%b wd=%h want 1000 5a5a5a5a", BusBe, BusWData); end
      BusAck = 1;
      @(negedge clk); BusAck = 0;
      checks++; if (Done !== 1'b1 || ReadData !== 32'hAA) begin errors++; $display("FAIL b2b_done: got done=%b rd=%h want 1 000000aa", Done, ReadData); end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk); idle_inputs(); issue(1, 0, 2'b10, 0, 32'h40, 0);
      @(negedge clk); Start = 0;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL rm_entered: got %b want 1", Stall); end
      reset = 1;
      @(negedge clk); reset = 0;
      checks++; if (BusReq !== 1'b0 || BusAddr !== 32'h0) begin errors++; $display("FAIL rm_abort: got req=%b addr=%h want 0 00000000", BusReq, BusAddr); end
      BusAck = 1; BusRData = 32'hFFFFFFFF;
      @(negedge clk); BusAck = 0;
      checks++; if (Done !== 1'b0 || TimeoutErr !== 1'b0 || ReadData !== 32'h0) begin errors++; $display("FAIL rm_lateack: got done=%b terr=%b rd=%h want 0 0 00000000", Done, TimeoutErr, ReadData); end
      @(negedge clk);
      checks++; if (Done !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL rm_after: got done=%b stall=%b want 0 0", Done, Stall); end
   endtask

   task automatic test_reset_priority();
      @(negedge clk); idle_inputs(); issue(1, 0, 2'b10, 0, 32'h80, 0);
      reset = 1;
      @(negedge clk); reset = 0; Start = 0;
      checks++; if (Stall !== 1'b0 || BusReq !== 1'b0 || BusAddr !== 32'h0) begin errors++; $display("FAIL rp_start: got stall=%b req=%b addr=%h want 0 0 00000000", Stall, BusReq, BusAddr); end
      @(negedge clk);
      checks++; if (Stall !== 1'b0 || MisalignErr !== 1'b0) begin errors++; $display("FAIL rp_after: got stall=%b mis=%b want 0 0", Stall, MisalignErr); end
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_store_half();
      test_load_half();
      test_misalign();
      test_timeout();
      test_ack_on_timeout_cycle();
      test_ignored();
      test_back_to_back();
      test_reset_mid_access();
      test_reset_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
